// File: rtl/sprite_pkg.sv
// sprite_pkg: shared encodings for the sprite rasteriser.
//   - draw mode encodings (mode input)
//   - orientation encodings (orient input)
//   - FSM state encodings for sprite_blitter
package sprite_pkg;

   localparam logic [1:0] MODE_DRAW        = 2'd0;
   localparam logic [1:0] MODE_TRANSPARENT = 2'd1;
   localparam logic [1:0] MODE_ERASE       = 2'd2;

   localparam logic [1:0] ORIENT_0   = 2'd0;
   localparam logic [1:0] ORIENT_90  = 2'd1;
   localparam logic [1:0] ORIENT_180 = 2'd2;
   localparam logic [1:0] ORIENT_270 = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_DONE = 2'd2
   } blit_state_e;

endpackage

// File: rtl/sprite_scan_counter.sv
// sprite_scan_counter: raster-order (row, col) walker over a SIZE x SIZE grid.
// Ports:
//   clock   in   system clock
//   reset   in   synchronous active-high reset
//   clear   in   force row/col to 0
//   enable  in   advance one position (col fastest)
//   row     out  current row
//   col     out  current column
//   last    out  high at (SIZE-1, SIZE-1)
module sprite_scan_counter #(
   parameter int SIZE = 5,
   parameter int CW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          clear,
   input  logic          enable,
   output logic [CW-1:0] row,
   output logic [CW-1:0] col,
   output logic          last
);

   localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

   logic [CW-1:0] row_q;
   logic [CW-1:0] col_q;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         row_q <= '0;
         col_q <= '0;
      end else if (enable) begin
         if (col_q == LAST) begin
            col_q <= '0;
            row_q <= (row_q == LAST) ? '0 : row_q + CW'(1);
         end else begin
            col_q <= col_q + CW'(1);
         end
      end
   end

   assign row  = row_q;
   assign col  = col_q;
   assign last = (row_q == LAST) && (col_q == LAST);

endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: rasterises one SIZE x SIZE sprite per start/done handshake,
// emitting one registered (x, y, col_out, plot) pixel per clock.
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   start / ready / done    request (taken only when ready), idle flag, end pulse
//   tile_x, tile_y          sprite tile coordinate (pixel base = tile * SIZE)
//   shape                   bitmap, MSB = top-left, row-major
//   colour, mode, orient    foreground colour, draw mode, rotation
//   x, y, col_out, plot     pixel write port towards the VGA adapter
//
// state   | meaning
// IDLE    | ready; start latches the request
// DRAW    | one pixel per cycle in raster order
// DONE    | first cycle: done pulses; second cycle: return to IDLE
import sprite_pkg::*;

module sprite_blitter #(
   parameter int SIZE  = 5,
   parameter int X_W   = 8,
   parameter int Y_W   = 7,
   parameter int COL_W = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   output logic                 ready,
   output logic                 done,
   input  logic [X_W-1:0]       tile_x,
   input  logic [Y_W-1:0]       tile_y,
   input  logic [SIZE*SIZE-1:0] shape,
   input  logic [COL_W-1:0]     colour,
   input  logic [1:0]           mode,
   input  logic [1:0]           orient,
   output logic [X_W-1:0]       x,
   output logic [Y_W-1:0]       y,
   output logic [COL_W-1:0]     col_out,
   output logic                 plot
);

   localparam int NPIX = SIZE * SIZE;
   localparam int CW   = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam int IW   = $clog2(NPIX);
   localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

   blit_state_e state_q, state_d;

   logic [X_W-1:0]   base_x_q;
   logic [Y_W-1:0]   base_y_q;
   logic [NPIX-1:0]  shape_q;
   logic [COL_W-1:0] colour_q;
   logic [1:0]       mode_q;
   logic [1:0]       orient_q;

   logic [X_W-1:0]   x_q, x_d;
   logic [Y_W-1:0]   y_q, y_d;
   logic [COL_W-1:0] col_q, col_d;
   logic             plot_q, plot_d;
   logic             done_q, done_d;

   logic             accept;
   logic             cnt_en;
   logic [CW-1:0]    row, col;
   logic             last;

   logic [CW-1:0]    src_r, src_c;
   int               bit_idx;
   logic             pix_bit;
   logic [COL_W-1:0] pix_col;

   sprite_scan_counter #(.SIZE(SIZE), .CW(CW)) u_scan (
      .clock  (clock),
      .reset  (reset),
      .clear  (accept),
      .enable (cnt_en),
      .row    (row),
      .col    (col),
      .last   (last)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start)  state_d = ST_DRAW;
         ST_DRAW: if (last)   state_d = ST_DONE;
         ST_DONE: if (done_q) state_d = ST_IDLE;
         default:             state_d = ST_IDLE;
      endcase
   end

   // Source pixel for the current destination (row, col) under rotation.
   always_comb begin
      src_r = row;
      src_c = col;
      case (orient_q)
         ORIENT_90:  begin src_r = LAST - col; src_c = row;        end
         ORIENT_180: begin src_r = LAST - row; src_c = LAST - col; end
         ORIENT_270: begin src_r = col;        src_c = LAST - row; end
         default:    begin src_r = row;        src_c = col;        end
      endcase
      bit_idx = NPIX - 1 - (int'(src_r) * SIZE + int'(src_c));
      pix_bit = shape_q[bit_idx[IW-1:0]];
   end

   always_comb begin
      ready   = (state_q == ST_IDLE);
      accept  = ready && start;
      cnt_en  = (state_q == ST_DRAW);
      plot_d  = 1'b0;
      done_d  = 1'b0;
      pix_col = '0;
      x_d     = x_q;
      y_d     = y_q;
      col_d   = col_q;
      case (state_q)
         ST_DRAW: begin
            case (mode_q)
               MODE_TRANSPARENT: begin plot_d = pix_bit; pix_col = colour_q; end
               MODE_ERASE:       begin plot_d = 1'b1;    pix_col = '0;       end
               default:          begin plot_d = 1'b1;    pix_col = pix_bit ? colour_q : '0; end
            endcase
            // Pixel fields only move when a pixel is actually written.
            if (plot_d) begin
               x_d   = base_x_q + X_W'(col);
               y_d   = base_y_q + Y_W'(row);
               col_d = pix_col;
            end
         end
         ST_DONE: done_d = ~done_q;
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         x_q      <= '0;
         y_q      <= '0;
         col_q    <= '0;
         plot_q   <= 1'b0;
         done_q   <= 1'b0;
         base_x_q <= '0;
         base_y_q <= '0;
         shape_q  <= '0;
         colour_q <= '0;
         mode_q   <= MODE_DRAW;
         orient_q <= ORIENT_0;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         col_q  <= col_d;
         plot_q <= plot_d;
         done_q <= done_d;
         if (accept) begin
            base_x_q <= X_W'(int'(tile_x) * SIZE);
            base_y_q <= Y_W'(int'(tile_y) * SIZE);
            shape_q  <= shape;
            colour_q <= colour;
            mode_q   <= mode;
            orient_q <= orient;
         end
      end
   end

   assign x       = x_q;
   assign y       = y_q;
   assign col_out = col_q;
   assign plot    = plot_q;
   assign done    = done_q;

endmodule

// File: tb/tb_sprite_blitter.sv
module tb_sprite_blitter;

   localparam int SIZE  = 5;
   localparam int X_W   = 8;
   localparam int Y_W   = 7;
   localparam int COL_W = 3;
   localparam int NCAP  = SIZE * SIZE + 2;

   logic                 clock;
   logic                 reset;
   logic                 start;
   logic                 ready;
   logic                 done;
   logic [X_W-1:0]       tile_x;
   logic [Y_W-1:0]       tile_y;
   logic [SIZE*SIZE-1:0] shape;
   logic [COL_W-1:0]     colour;
   logic [1:0]           mode;
   logic [1:0]           orient;
   logic [X_W-1:0]       x;
   logic [Y_W-1:0]       y;
   logic [COL_W-1:0]     col_out;
   logic                 plot;

   sprite_blitter #(.SIZE(SIZE), .X_W(X_W), .Y_W(Y_W), .COL_W(COL_W)) dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .ready   (ready),
      .done    (done),
      .tile_x  (tile_x),
      .tile_y  (tile_y),
      .shape   (shape),
      .colour  (colour),
      .mode    (mode),
      .orient  (orient),
      .x       (x),
      .y       (y),
      .col_out (col_out),
      .plot    (plot)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Samples taken #1 after edge k (k = 1..NCAP) following the accept edge.
   logic [X_W-1:0]   cap_x    [0:NCAP];
   logic [Y_W-1:0]   cap_y    [0:NCAP];
   logic [COL_W-1:0] cap_col  [0:NCAP];
   logic             cap_plot [0:NCAP];
   logic             cap_done [0:NCAP];
   logic             cap_rdy  [0:NCAP];
   int n_plot, n_done, n_fg;

   localparam logic [24:0] TOP_ROW = 25'b11111_00000_00000_00000_00000;

   task automatic run(input logic [X_W-1:0] tx, input logic [Y_W-1:0] ty,
                      input logic [24:0] shp, input logic [COL_W-1:0] c,
                      input logic [1:0] md, input logic [1:0] ori, input int extra);
      @(negedge clock);
      tile_x = tx; tile_y = ty; shape = shp; colour = c; mode = md; orient = ori;
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      n_plot = 0; n_done = 0; n_fg = 0;
      for (int k = 1; k <= NCAP; k++) begin
         @(posedge clock);
         #1;
         cap_x[k] = x; cap_y[k] = y; cap_col[k] = col_out;
         cap_plot[k] = plot; cap_done[k] = done; cap_rdy[k] = ready;
         if (plot) n_plot++;
         if (done) n_done++;
         if (plot && col_out == 3'd6) n_fg++;
         if (k == extra) begin
            start = 1'b1; tile_x = '0; tile_y = '0; colour = 3'd1; mode = 2'd0;
         end else begin
            start = 1'b0;
         end
      end
   endtask

   int quiet_plot, quiet_done;
   task automatic watch_quiet(input int cycles);
      quiet_plot = 0; quiet_done = 0;
      for (int k = 0; k < cycles; k++) begin
         @(posedge clock);
         #1;
         if (plot) quiet_plot++;
         if (done) quiet_done++;
      end
   endtask

   int bad_pos;

   initial begin
      reset = 1'b1; start = 1'b0;
      tile_x = '0; tile_y = '0; shape = '0; colour = '0; mode = '0; orient = '0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      chk("rst_ready", ready, 1);
      chk("rst_plot", plot, 0);
      chk("rst_done", done, 0);
      chk("rst_x", x, 0);
      chk("rst_y", y, 0);
      chk("rst_col", col_out, 0);

      // DRAW, top row, orient 0, tile (2,3)
      run(8'd2, 7'd3, TOP_ROW, 3'd6, 2'd0, 2'd0, 0);
      chk("draw_nplot", n_plot, 25);
      chk("draw_p0_x", cap_x[1], 10);
      chk("draw_p0_y", cap_y[1], 15);
      chk("draw_p0_col", cap_col[1], 6);
      chk("draw_p4_x", cap_x[5], 14);
      chk("draw_p4_col", cap_col[5], 6);
      chk("draw_p5_x", cap_x[6], 10);
      chk("draw_p5_y", cap_y[6], 16);
      chk("draw_p5_col", cap_col[6], 0);
      chk("draw_nfg", n_fg, 5);
      chk("draw_last_x", cap_x[25], 14);
      chk("draw_last_y", cap_y[25], 19);
      chk("draw_last_plot", cap_plot[25], 1);
      chk("draw_plot26", cap_plot[26], 0);
      chk("draw_done25", cap_done[25], 0);
      chk("draw_done26", cap_done[26], 1);
      chk("draw_ndone", n_done, 1);
      chk("draw_rdy1", cap_rdy[1], 0);
      chk("draw_rdy26", cap_rdy[26], 0);
      chk("draw_rdy27", cap_rdy[27], 1);

      // TRANSPARENT
      run(8'd2, 7'd3, TOP_ROW, 3'd6, 2'd1, 2'd0, 0);
      chk("tr_nplot", n_plot, 5);
      chk("tr_nfg", n_fg, 5);
      chk("tr_p0_x", cap_x[1], 10);
      chk("tr_p4_x", cap_x[5], 14);
      chk("tr_p4_y", cap_y[5], 15);
      chk("tr_plot6", cap_plot[6], 0);
      chk("tr_done26", cap_done[26], 1);
      chk("tr_rdy27", cap_rdy[27], 1);

      // orient 90 cw: top row lands in rightmost column (x=14)
      run(8'd2, 7'd3, TOP_ROW, 3'd6, 2'd0, 2'd1, 0);
      bad_pos = 0;
      for (int k = 1; k <= 25; k++) begin
         if (cap_col[k] != ((((k - 1) % 5) == 4) ? 3'd6 : 3'd0)) bad_pos++;
      end
      chk("o90_badpos", bad_pos, 0);
      chk("o90_nfg", n_fg, 5);
      chk("o90_p4_col", cap_col[5], 6);
      chk("o90_p24_x", cap_x[25], 14);
      chk("o90_p24_col", cap_col[25], 6);
      chk("o90_p0_col", cap_col[1], 0);

      // orient 180: top row becomes bottom row (pixels 20..24)
      run(8'd2, 7'd3, TOP_ROW, 3'd6, 2'd0, 2'd2, 0);
      chk("o180_nfg", n_fg, 5);
      chk("o180_p20_col", cap_col[21], 6);
      chk("o180_p19_col", cap_col[20], 0);

      // orient 270: top row becomes leftmost column
      run(8'd2, 7'd3, TOP_ROW, 3'd6, 2'd0, 2'd3, 0);
      chk("o270_nfg", n_fg, 5);
      chk("o270_p5_col", cap_col[6], 6);
      chk("o270_p4_col", cap_col[5], 0);

      // ERASE with start pulsed mid-draw (ignored, inputs changed)
      run(8'd2, 7'd3, 25'h1FFFFFF, 3'd7, 2'd2, 2'd0, 5);
      chk("er_nplot", n_plot, 25);
      bad_pos = 0;
      for (int k = 1; k <= 25; k++) if (cap_col[k] != 3'd0) bad_pos++;
      chk("er_nonzero", bad_pos, 0);
      chk("er_last_x", cap_x[25], 14);
      chk("er_last_y", cap_y[25], 19);
      chk("er_ndone", n_done, 1);
      watch_quiet(40);
      chk("er_no_second", quiet_plot, 0);

      // Reset mid-draw after pixel 10
      @(negedge clock);
      tile_x = 8'd2; tile_y = 7'd3; shape = TOP_ROW; colour = 3'd6; mode = 2'd0; orient = 2'd0;
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (11) @(posedge clock);
      #1;
      chk("rm_p10_plot", plot, 1);
      chk("rm_p10_x", x, 10);
      chk("rm_p10_y", y, 17);
      reset = 1'b1;
      @(posedge clock);
      #1;
      chk("rm_plot", plot, 0);
      chk("rm_ready", ready, 1);
      chk("rm_done", done, 0);
      reset = 1'b0;
      watch_quiet(40);
      chk("rm_quiet_plot", quiet_plot, 0);
      chk("rm_quiet_done", quiet_done, 0);
      run(8'd2, 7'd3, TOP_ROW, 3'd6, 2'd0, 2'd0, 0);
      chk("rm_fresh_nplot", n_plot, 25);
      chk("rm_fresh_done", cap_done[26], 1);

      // Coordinate wrap
      run(8'd60, 7'd30, TOP_ROW, 3'd6, 2'd0, 2'd0, 0);
      chk("wr_p0_x", cap_x[1], 44);
      chk("wr_p0_y", cap_y[1], 22);
      chk("wr_last_x", cap_x[25], 48);
      chk("wr_last_y", cap_y[25], 26);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Parametrised NxN sprite rasteriser; successor to the fixed 5x5 data/counter pair.
- Takes a tile coordinate, a flat shape bitmap, a colour, a draw mode and an orientation.
- Emits one pixel per clock as an (x, y, colour, plot) stream into the VGA adapter write port.
- Sits between control_master's game FSM (one start/done handshake per sprite) and vga_adapter.

Parameters:
- SIZE, 5, sprite edge length in pixels; tile-to-pixel scale factor (2..8).
- X_W, 8, pixel x width.
- Y_W, 7, pixel y width.
- COL_W, 3, colour width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when ready=1
- ready  out  1  block idle; combinational from state
- done  out  1  one-cycle pulse after the last pixel
- tile_x  in  X_W  sprite tile column; latched on accept
- tile_y  in  Y_W  sprite tile row; latched on accept
- shape  in  SIZE*SIZE  bitmap, MSB = top-left, row-major; latched on accept
- colour  in  COL_W  foreground colour; latched on accept
- mode  in  2  0=DRAW, 1=TRANSPARENT, 2=ERASE, 3=reserved (behaves as DRAW); latched on accept
- orient  in  2  0=0deg, 1=90deg cw, 2=180deg, 3=270deg cw; latched on accept
- x  out  X_W  pixel x (registered)
- y  out  Y_W  pixel y (registered)
- col_out  out  COL_W  pixel colour (registered)
- plot  out  1  pixel write strobe (registered)

Behaviour:
- Reset values: state=IDLE; x=0; y=0; col_out=0; plot=0; done=0; row=col=0.
- FSM states: IDLE, DRAW, DONE.
- IDLE: ready=1. start=1 latches all inputs, sets base_x=tile_x*SIZE and base_y=tile_y*SIZE, clears row/col, and moves to DRAW.
- Base arithmetic is truncated modulo 2^X_W / 2^Y_W.
- start while not IDLE: ignored; latched inputs are unchanged.
- DRAW: one destination pixel (row, col) is issued per cycle in raster order, col fastest.
  - Next edge: x <= base_x + col, y <= base_y + row (both truncated).
- Source pixel (r, c) by orient:
  - 0: (row, col)
  - 1: (SIZE-1-col, row)
  - 2: (SIZE-1-row, SIZE-1-col)
  - 3: (col, SIZE-1-row)
- Bit used: shape[SIZE*SIZE-1 - (r*SIZE + c)].
- Colour and strobe per mode:
  - DRAW: plot=1; col_out = bit ? colour : 0.
  - TRANSPARENT: plot = bit; col_out = colour.
  - ERASE: plot=1; col_out = 0.
- Counter: col wraps SIZE-1 -> 0 and increments row. Leave DRAW for DONE after issuing (SIZE-1, SIZE-1).
- DONE: plot <= 0, done <= 1 for exactly one cycle, then IDLE. start is not accepted in DONE.
- Latency:
  - start accepted at edge 0.
  - Pixel k (0..SIZE*SIZE-1) is valid on outputs after edge k+1.
  - done is high after edge SIZE*SIZE+1.
  - ready returns after edge SIZE*SIZE+2.
  - Total occupancy SIZE*SIZE+2 cycles.
- Reset mid-operation: on the next edge plot=0, done=0, state=IDLE. No partial pixels follow.
- x/y/col_out hold their last values while plot=0.

Decomposition:
- Package sprite_pkg holds:
  - MODE_DRAW/MODE_TRANSPARENT/MODE_ERASE encodings
  - ORIENT_0/90/180/270 encodings
  - FSM state encodings
- Sub-module sprite_scan_counter:
  - Parametrised by SIZE.
  - Ports: clock, reset, clear, enable, row, col, last.
  - Generalises the 5x5 counter; last is asserted at (SIZE-1, SIZE-1).
- Orientation mapping and bit select stay in sprite_blitter as combinational logic.

Test Plan:
- DRAW: SIZE=5, tile (2,3), shape=25'b11111_00000_00000_00000_00000, colour=3'b110, orient 0.
  - Required: 25 plot pulses.
  - First pixel x=10, y=15, col_out=6; pixels 0..4 col_out=6, pixels 5..24 col_out=0.
  - Last pixel x=14, y=19; done pulses 26 cycles after accept; ready 27 cycles after accept.
- TRANSPARENT, same shape: exactly 5 plot pulses, at (10..14, 15), col_out=6. The other 20 cycles have plot=0; timing is unchanged.
- orient=1 (90deg cw), same top-row shape, DRAW: col_out=6 exactly where col==4 (x=14, y=15..19); all other pixels col_out=0.
- ERASE, shape all ones, colour 7: 25 plots, all col_out=0. start pulsed at cycle 5 is ignored and no second sprite follows.
- Reset mid-draw: assert reset after pixel 10. Next cycle plot=0, ready=1, done never pulses. A fresh start then draws a full 25 pixels.
- Wrap: tile_x=60, tile_y=30 -> base_x=300 mod 256=44, base_y=150 mod 128=22. Last pixel x=48, y=26.
